// File: rtl/counter_pkg.sv
// Shared types and default sizes for the programmable up/down counter family.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_STEP_W  = 4;
  localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/count_prescaler.sv
// Enable prescaler: one tick every (i_presc+1) enabled cycles; phase holds while disabled.
module count_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               o_tick
);

  logic [PRESC_W-1:0] pcnt_q;
  logic [PRESC_W-1:0] pcnt_d;
  logic               hit_s;

  assign hit_s  = (pcnt_q == i_presc);
  assign o_tick = i_en & hit_s;

  // Phase counter next state: a clear restarts the period, a hit closes it.
  always_comb begin
    pcnt_d = pcnt_q;
    if (i_clr) begin
      pcnt_d = {PRESC_W{1'b0}};
    end else if (i_en) begin
      if (hit_s) begin
        pcnt_d = {PRESC_W{1'b0}};
      end else begin
        pcnt_d = pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Phase counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pcnt_q <= {PRESC_W{1'b0}};
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/updown_counter_pro.sv
// Programmable-modulus up/down counter with step, wrap/saturate, prescaler and
// pulse plus sticky overflow/underflow flags. Assumes STEP_W <= WIDTH+2.
module updown_counter_pro
  import counter_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          STEP_W    = DEF_STEP_W,
  parameter int          PRESC_W   = DEF_PRESC_W,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_up_down,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_load_data,
  input  logic [WIDTH-1:0]   i_max,
  input  logic [STEP_W-1:0]  i_step,
  input  mode_e              i_mode,
  input  logic [PRESC_W-1:0] i_presc,
  input  logic               i_clr_flags,
  output logic [WIDTH-1:0]   o_count,
  output logic               o_ovf,
  output logic               o_udf,
  output logic               o_ovf_sticky,
  output logic               o_udf_sticky,
  output logic               o_tc
);

  localparam int EW = WIDTH + 2;

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             ovf_sticky_q, ovf_sticky_d, udf_sticky_q, udf_sticky_d;
  logic             tick_s;
  logic [EW-1:0]    cnt_x_s, step_x_s, max_x_s, max1_x_s, sum_x_s;

  count_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_clr   (i_load),
    .i_presc (i_presc),
    .o_tick  (tick_s)
  );

  // Two guard bits keep count+step and count+(max+1) exact at full range.
  assign cnt_x_s  = {2'b00, count_q};
  assign step_x_s = {{(EW-STEP_W){1'b0}}, i_step};
  assign max_x_s  = {2'b00, i_max};
  assign max1_x_s = max_x_s + {{(EW-1){1'b0}}, 1'b1};
  assign sum_x_s  = cnt_x_s + step_x_s;

  // Next count and flag pulses; load outranks a tick and never raises flags.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (i_load) begin
      count_d = (i_load_data > i_max) ? i_max : i_load_data;
    end else if (tick_s && (i_step != {STEP_W{1'b0}})) begin
      if (i_up_down) begin
        if (sum_x_s > max_x_s) begin
          ovf_d   = 1'b1;
          count_d = (i_mode == MODE_SAT) ? i_max : WIDTH'(sum_x_s - max1_x_s);
        end else begin
          count_d = WIDTH'(sum_x_s);
        end
      end else begin
        if (cnt_x_s < step_x_s) begin
          udf_d   = 1'b1;
          count_d = (i_mode == MODE_SAT) ? {WIDTH{1'b0}}
                                         : WIDTH'(cnt_x_s + max1_x_s - step_x_s);
        end else begin
          count_d = WIDTH'(cnt_x_s - step_x_s);
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // A new event wins over a same-cycle clear.
  assign ovf_sticky_d = ovf_d | (ovf_sticky_q & ~i_clr_flags);
  assign udf_sticky_d = udf_d | (udf_sticky_q & ~i_clr_flags);

  // Count and flag registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q      <= WIDTH'(RESET_VAL);
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  assign o_count      = count_q;
  assign o_ovf        = ovf_q;
  assign o_udf        = udf_q;
  assign o_ovf_sticky = ovf_sticky_q;
  assign o_udf_sticky = udf_sticky_q;
  assign o_tc         = (i_up_down && (count_q == i_max)) ||
                        (!i_up_down && (count_q == {WIDTH{1'b0}}));

endmodule

// File: tb/tb_updown_counter_pro.sv
// Scoreboard bench: directed scenarios then random traffic against an integer reference model.
module tb_updown_counter_pro;
  import counter_pkg::*;

  localparam int W  = 8;
  localparam int SW = 4;
  localparam int PW = 8;
  localparam int RV = 0;

  logic          clk = 1'b0;
  logic          rst, en, up, load, clr;
  logic [W-1:0]  ld, mx;
  logic [SW-1:0] step;
  mode_e         mode;
  logic [PW-1:0] presc;
  logic [W-1:0]  count;
  logic          ovf, udf, ovf_st, udf_st, tc;

  always #5 clk = ~clk;

  updown_counter_pro #(
    .WIDTH(W), .STEP_W(SW), .PRESC_W(PW), .RESET_VAL(RV)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_down(up), .i_load(load),
    .i_load_data(ld), .i_max(mx), .i_step(step), .i_mode(mode),
    .i_presc(presc), .i_clr_flags(clr), .o_count(count), .o_ovf(ovf),
    .o_udf(udf), .o_ovf_sticky(ovf_st), .o_udf_sticky(udf_st), .o_tc(tc)
  );

  typedef struct {
    int count;
    bit ovf, udf, os, us;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   m_count = 0, m_pcnt = 0;
  bit   m_os = 1'b0, m_us = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: one clock edge of counter behaviour from the sampled inputs.
  task automatic model_step();
    exp_t e;
    int   s, maxv, stp;
    bit   tick;
    e.ovf = 1'b0;
    e.udf = 1'b0;
    maxv  = int'(mx);
    stp   = int'(step);
    if (rst) begin
      m_count = RV; m_pcnt = 0; m_os = 1'b0; m_us = 1'b0;
    end else begin
      tick = en && (m_pcnt == int'(presc));
      if (en) m_pcnt = tick ? 0 : (m_pcnt + 1) % (1 << PW);
      if (load) begin
        m_count = (int'(ld) > maxv) ? maxv : int'(ld);
        m_pcnt  = 0;
      end else if (tick && stp > 0) begin
        if (up) begin
          s = m_count + stp;
          if (s > maxv) begin
            e.ovf   = 1'b1;
            m_count = (mode == MODE_SAT) ? maxv : s - (maxv + 1);
          end else begin
            m_count = s;
          end
        end else if (m_count < stp) begin
          e.udf   = 1'b1;
          m_count = (mode == MODE_SAT) ? 0 : m_count + maxv + 1 - stp;
        end else begin
          m_count = m_count - stp;
        end
      end
      m_os = e.ovf || (m_os && !clr);
      m_us = e.udf || (m_us && !clr);
    end
    e.count = m_count;
    e.os    = m_os;
    e.us    = m_us;
    sb.push_back(e);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      model_step();
      @(negedge clk);
    end
  endtask

  // Monitor: every edge the DUT presents a new state; compare with the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("sb_count", 32'(count), 32'(mon_e.count));
        chk("sb_ovf", 32'(ovf), 32'(mon_e.ovf));
        chk("sb_udf", 32'(udf), 32'(mon_e.udf));
        chk("sb_ovf_sticky", 32'(ovf_st), 32'(mon_e.os));
        chk("sb_udf_sticky", 32'(udf_st), 32'(mon_e.us));
        chk("sb_tc", 32'(tc),
            32'((up && mon_e.count == int'(mx)) || (!up && mon_e.count == 0)));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; clr = 1'b0;
    ld = 8'd0; mx = 8'd9; step = 4'd1; mode = MODE_WRAP; presc = 8'd0;

    // Reset and basic wrap
    run(2);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    run(9);
    chk("at_max_count", 32'(count), 32'd9);
    chk("at_max_tc", 32'(tc), 32'd1);
    chk("at_max_ovf", 32'(ovf), 32'd0);
    run(1);
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_ovf", 32'(ovf), 32'd1);

    // Step wrap 8 -> 1
    ld = 8'd8; load = 1'b1; run(1);
    load = 1'b0; step = 4'd3; run(1);
    chk("stepwrap_count", 32'(count), 32'd1);
    chk("stepwrap_ovf", 32'(ovf), 32'd1);

    // Full range 254 + 3 -> 1
    mx = 8'd255; ld = 8'd254; load = 1'b1; run(1);
    load = 1'b0; run(1);
    chk("full_count", 32'(count), 32'd1);
    chk("full_ovf", 32'(ovf), 32'd1);

    // Down saturate and sticky clear behaviour
    ld = 8'd2; load = 1'b1; up = 1'b0; mode = MODE_SAT; run(1);
    load = 1'b0; run(1);
    chk("dsat_count", 32'(count), 32'd0);
    chk("dsat_udf", 32'(udf), 32'd1);
    chk("dsat_sticky", 32'(udf_st), 32'd1);
    run(1);
    chk("dsat_repulse", 32'(udf), 32'd1);
    step = 4'd0; clr = 1'b1; run(1);
    chk("clr_noevent", 32'(udf_st), 32'd0);
    step = 4'd3; run(1);
    chk("clr_event_sticky", 32'(udf_st), 32'd1);
    clr = 1'b0;

    // Prescaler period 4 with a 2-cycle enable gap
    step = 4'd1; up = 1'b1; mode = MODE_WRAP; presc = 8'd3; ld = 8'd0; load = 1'b1; run(1);
    load = 1'b0; run(3);
    chk("presc_hold", 32'(count), 32'd0);
    run(1);
    chk("presc_tick", 32'(count), 32'd1);
    run(2); en = 1'b0; run(2); en = 1'b1; run(1);
    chk("presc_delayed", 32'(count), 32'd1);
    run(1);
    chk("presc_after_gap", 32'(count), 32'd2);

    // Load clamp coincident with a tick, then prescaler restart, then reset
    run(3);
    mx = 8'd9; ld = 8'd200; load = 1'b1; run(1);
    chk("clamp_count", 32'(count), 32'd9);
    chk("clamp_noflag", 32'({ovf, udf}), 32'd0);
    load = 1'b0; run(3);
    chk("load_presc_restart", 32'(count), 32'd9);
    run(1);
    chk("post_load_wrap", 32'(count), 32'd0);
    run(4);
    rst = 1'b1; run(1);
    chk("midrst_count", 32'(count), 32'(RV));
    chk("midrst_flags", 32'({ovf, udf, ovf_st, udf_st}), 32'd0);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(63) == 0);
      load = ($urandom_range(15) == 0);
      en   = ($urandom_range(3) != 0);
      up   = 1'($urandom_range(1));
      mode = mode_e'($urandom_range(1));
      clr  = ($urandom_range(7) == 0);
      ld   = W'($urandom_range(255));
      if ($urandom_range(31) == 0) mx = W'($urandom_range(255));
      if ($urandom_range(31) == 0) presc = PW'($urandom_range(3));
      step = (mx >= 8'd14) ? SW'($urandom_range(15)) : SW'($urandom_range(int'(mx) + 1));
      run(1);
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
